// File: rtl/assert_evt_pkg.sv
// Shared types and defaults for the assertion event collector.
// Timestamp storage is built only when ASSERT_EVT_TS_EN is defined.
package assert_evt_pkg;

  localparam int unsigned TS_W_DEF  = 16;
  localparam int unsigned DEPTH_DEF = 4;

  // Entry fields are sized for the largest legal NUM_CHK (32) and TS_W (32).
  localparam int unsigned ID_W_MAX = 5;
  localparam int unsigned TS_W_MAX = 32;

  typedef struct packed {
    logic [ID_W_MAX-1:0] id;
    logic [TS_W_MAX-1:0] ts;
  } evt_entry_t;

endpackage

// File: rtl/assert_evt_if.sv
// Event stream handshake: the collector is master, the consumer is slave.
interface assert_evt_if #(
  parameter int unsigned ID_W = 3,
  parameter int unsigned TS_W = 16
);
  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic [TS_W-1:0] evt_ts;

  modport master (output evt_valid, output evt_id, output evt_ts, input evt_ready);
  modport slave  (input evt_valid, input evt_id, input evt_ts, output evt_ready);
endinterface

// File: rtl/assert_evt_fifo.sv
// Valid/ready FIFO with wrap-bit pointers; head data reads as zero when empty.
module assert_evt_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         full,
  output logic         empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         push, pop;

  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    out_valid = !empty;
    // A full FIFO still accepts when the head leaves on the same edge.
    in_ready  = !full || out_ready;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    out_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = in_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/assert_evt_collector.sv
// Collects rising edges of assertion-checker fail lines into a timestamped event FIFO.
// Optional ASSERT_EVT_TS_EN adds the free-running timestamp counter and per-entry ts.
module assert_evt_collector
  import assert_evt_pkg::*;
#(
  parameter int unsigned NUM_CHK = 8,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned TS_W    = TS_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CHK-1:0] fire,
  input  logic               clr,
  assert_evt_if.master       evt,
  output logic [NUM_CHK-1:0] sticky,
  output logic               overflow,
  output logic               irq
);
  localparam int unsigned ID_W = $clog2(NUM_CHK);
`ifdef ASSERT_EVT_TS_EN
  localparam int unsigned DATA_W = ID_W + TS_W;
`else
  localparam int unsigned DATA_W = ID_W;
`endif

  logic [NUM_CHK-1:0] fire_prev_q, fire_prev_d;
  logic [NUM_CHK-1:0] pending_q, pending_d;
  logic [NUM_CHK-1:0] sticky_q, sticky_d;
  logic               overflow_q, overflow_d;
  logic               armed_q, armed_d;
  logic [NUM_CHK-1:0] new_evt, loss, push_mask;
  logic               sel_found, push_ready, push_fire;
  logic [ID_W-1:0]    sel_idx;
  evt_entry_t         push_entry;
  logic [DATA_W-1:0]  fifo_in, fifo_out;
  logic               fifo_full, fifo_empty, unused_sink;

`ifdef ASSERT_EVT_TS_EN
  logic [TS_W-1:0] ts_q, ts_d;

  always_comb ts_d = ts_q + TS_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts_q <= '0;
    else      ts_q <= ts_d;
  end
`endif

  always_comb begin
    fire_prev_d = fire;
    armed_d     = 1'b1;
    // No edges are seen until fire has been sampled once after reset.
    new_evt     = armed_q ? (fire & ~fire_prev_q) : '0;
    sel_found   = 1'b0;
    sel_idx     = '0;
    for (int unsigned i = 0; i < NUM_CHK; i++) begin
      if (pending_q[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'(i);
      end
    end
    push_fire = sel_found && push_ready;
    push_mask = '0;
    if (push_fire) push_mask[sel_idx] = 1'b1;
    loss       = new_evt & pending_q & ~push_mask;
    pending_d  = (pending_q & ~push_mask) | new_evt;
    sticky_d   = (clr ? '0 : sticky_q) | new_evt;
    overflow_d = (clr ? 1'b0 : overflow_q) | (|loss);
  end

  always_comb begin
    push_entry = '0;
    push_entry.id[ID_W-1:0] = sel_idx;
`ifdef ASSERT_EVT_TS_EN
    push_entry.ts[TS_W-1:0] = ts_q;
    fifo_in = {push_entry.id[ID_W-1:0], push_entry.ts[TS_W-1:0]};
`else
    fifo_in = push_entry.id[ID_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fire_prev_q <= '0;
      pending_q   <= '0;
      sticky_q    <= '0;
      overflow_q  <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      fire_prev_q <= fire_prev_d;
      pending_q   <= pending_d;
      sticky_q    <= sticky_d;
      overflow_q  <= overflow_d;
      armed_q     <= armed_d;
    end
  end

  assert_evt_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .in_valid  (sel_found),
    .in_ready  (push_ready),
    .in_data   (fifo_in),
    .out_valid (evt.evt_valid),
    .out_ready (evt.evt_ready),
    .out_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign unused_sink = ^push_entry ^ fifo_full ^ fifo_empty;

  assign evt.evt_id = fifo_out[DATA_W-1 -: ID_W];
`ifdef ASSERT_EVT_TS_EN
  assign evt.evt_ts = fifo_out[TS_W-1:0];
`else
  assign evt.evt_ts = '0;
`endif

  assign sticky   = sticky_q;
  assign overflow = overflow_q;
  assign irq      = (|sticky_q) | overflow_q;

endmodule
